// File: rtl/io_pkg.sv
// Shared types and constants for the board-input conditioning front end.
package io_pkg;

  // Debounce state of one push-button.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 10 ms at a 100 MHz system clock.
  localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;

  // Button lane indices inside the packed button vectors of the top level.
  localparam int unsigned NUM_BTN = 2;
  localparam int unsigned BTN_L   = 0;
  localparam int unsigned BTN_R   = 1;

  // The debounced level is high once a press has been accepted, and it stays
  // high while a release is still being qualified.
  function automatic logic is_held_state(input btn_state_t st);
    return (st == PRESSED) || (st == RELEASE_WAIT);
  endfunction

endpackage : io_pkg

// File: rtl/btn_debounce.sv
// Single push-button conditioner: 2-flop synchroniser, debounce FSM with a
// saturating window counter, registered press pulse and debounced level.
// DEBOUNCE_CYCLES must be at least 2.
module btn_debounce
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,    // asynchronous, active low
  input  logic raw,    // asynchronous, bouncy
  output logic pulse,  // one cycle per accepted press
  output logic held    // debounced level
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  btn_state_t       state_q;
  btn_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pulse_q;
  logic             pulse_d;
  logic             held_q;
  logic             held_d;

  // Bring the raw input into the clk domain; only s2 is used below.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // Next-state logic: a level change is accepted only after the synchronised
  // input has stayed at the new level for the whole window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to 1 resumes the press without a second pulse.
        if (s2_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = is_held_state(state_d);
  end

  // FSM state, window counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
    end
  end

  assign pulse = pulse_q;
  assign held  = held_q;

endmodule : btn_debounce

// File: rtl/io_input_conditioner.sv
// Front-end conditioning for the memory-mapped IO port: two debounced
// push-buttons producing press pulses, plus a switch bank debounced as one
// word so the port never latches a half-updated value.
// DEBOUNCE_CYCLES must be at least 2.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned SW_WIDTH        = 16
) (
  input  logic                clk,
  input  logic                rst,         // asynchronous, active low
  input  logic                btnL_raw,
  input  logic                btnR_raw,
  input  logic [SW_WIDTH-1:0] switch_raw,
  output logic                buttonL,
  output logic                buttonR,
  output logic                heldL,
  output logic                heldR,
  output logic [SW_WIDTH-1:0] switch
);

  localparam int unsigned      CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] SCNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Buttons: identical, fully independent lanes.
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_pulse;
  logic [NUM_BTN-1:0] btn_held;

  assign btn_raw[BTN_L] = btnL_raw;
  assign btn_raw[BTN_R] = btnR_raw;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_raw[gi]),
        .pulse(btn_pulse[gi]),
        .held (btn_held[gi])
      );
    end
  endgenerate

  assign buttonL = btn_pulse[BTN_L];
  assign buttonR = btn_pulse[BTN_R];
  assign heldL   = btn_held[BTN_L];
  assign heldR   = btn_held[BTN_R];

  // ---------------------------------------------------------------------------
  // Switch bank: one shared window for the whole word.
  // ---------------------------------------------------------------------------
  logic [SW_WIDTH-1:0] sw_s1_q;
  logic [SW_WIDTH-1:0] sw_s2_q;
  logic [SW_WIDTH-1:0] cand_q;
  logic [SW_WIDTH-1:0] cand_d;
  logic [CNT_W-1:0]    scnt_q;
  logic [CNT_W-1:0]    scnt_d;
  logic [SW_WIDTH-1:0] switch_q;
  logic [SW_WIDTH-1:0] switch_d;

  // Per-bit 2-flop synchroniser; bits may resolve on different cycles, which
  // the word-level window below absorbs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= switch_raw;
      sw_s2_q <= sw_s1_q;
    end
  end

  // Any bit change restarts the window; the output is replaced as a whole
  // word once the candidate has been stable for the full window.
  always_comb begin
    cand_d   = cand_q;
    scnt_d   = scnt_q;
    switch_d = switch_q;
    if (sw_s2_q != cand_q) begin
      cand_d = sw_s2_q;
      scnt_d = '0;
    end else if (scnt_q == SCNT_LAST) begin
      // Counter saturates here; reloading the same word is harmless.
      switch_d = cand_q;
    end else begin
      scnt_d = scnt_q + CNT_W'(1);
    end
  end

  // Switch candidate, window counter and published word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand_q   <= '0;
      scnt_q   <= '0;
      switch_q <= '0;
    end else begin
      cand_q   <= cand_d;
      scnt_q   <= scnt_d;
      switch_q <= switch_d;
    end
  end

  assign switch = switch_q;

endmodule : io_input_conditioner

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner with a 4-cycle debounce window.
module tb_io_input_conditioner;

  localparam int unsigned N   = 4;
  localparam int unsigned SWW = 16;
  // A level is accepted after N+1 consecutive identical synchronised samples.
  localparam int unsigned WIN = N + 1;

  logic            clk;
  logic            rst_n;
  logic            btnL_raw;
  logic            btnR_raw;
  logic [SWW-1:0]  switch_raw;
  logic            buttonL;
  logic            buttonR;
  logic            heldL;
  logic            heldR;
  logic [SWW-1:0]  switch;

  io_input_conditioner #(
    .DEBOUNCE_CYCLES(N),
    .SW_WIDTH       (SWW)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .btnL_raw  (btnL_raw),
    .btnR_raw  (btnR_raw),
    .switch_raw(switch_raw),
    .buttonL   (buttonL),
    .buttonR   (buttonR),
    .heldL     (heldL),
    .heldR     (heldR),
    .switch    (switch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: keeps a history of raw samples since the last reset,
  // delays it by two edges, and accepts a new level once the last WIN
  // delayed samples all agree on it.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0]     btn;   // [0]=left, [1]=right
    logic [SWW-1:0] sw;
  } samp_t;

  samp_t          raw_log[$];
  samp_t          vis_log[$];
  logic [1:0]     m_level = '0;
  logic [1:0]     m_pulse = '0;
  logic [SWW-1:0] m_sw    = '0;

  task automatic model_edge();
    samp_t cur;
    samp_t vis;
    bit    all_opp;
    bit    all_same;
    if (!rst_n) begin
      raw_log.delete();
      vis_log.delete();
      m_level = '0;
      m_pulse = '0;
      m_sw    = '0;
    end else begin
      cur.btn = {btnR_raw, btnL_raw};
      cur.sw  = switch_raw;
      raw_log.push_back(cur);
      if (raw_log.size() >= 3) vis = raw_log[raw_log.size()-3];
      else                     vis = '0;
      if (raw_log.size() > 3) void'(raw_log.pop_front());
      vis_log.push_back(vis);
      if (vis_log.size() > WIN) void'(vis_log.pop_front());
      m_pulse = '0;
      if (vis_log.size() == WIN) begin
        for (int b = 0; b < 2; b++) begin
          all_opp = 1'b1;
          for (int i = 0; i < int'(WIN); i++)
            if (vis_log[i].btn[b] == m_level[b]) all_opp = 1'b0;
          if (all_opp) begin
            m_level[b] = ~m_level[b];
            m_pulse[b] = m_level[b];
          end
        end
        all_same = 1'b1;
        for (int i = 0; i < int'(WIN); i++)
          if (vis_log[i].sw != vis.sw) all_same = 1'b0;
        if (all_same) m_sw = vis.sw;
      end
    end
  endtask

  // One clock: model follows the edge, outputs checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("buttonL", buttonL, m_pulse[0]);
    chk("buttonR", buttonR, m_pulse[1]);
    chk("heldL",   heldL,   m_level[0]);
    chk("heldR",   heldR,   m_level[1]);
    chk("switch",  switch,  m_sw);
  endtask

  // ---------------------------------------------------------------------------
  // Hand-computed vector table: reset, then a clean left press.
  // Row 2 is the first edge sampling btnL_raw=1; pulse appears after row 8.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic           rst_n;
    logic           bl;
    logic           br;
    logic [SWW-1:0] sw;
    logic           e_pl;
    logic           e_pr;
    logic           e_hl;
    logic           e_hr;
    logic [SWW-1:0] e_sw;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int pulses;
    int lows;
    int idx_l;
    int idx_r;
    int idx_sw;
    int saw_a5;
    int idx;

    rst_n      = 1'b0;
    btnL_raw   = 1'b0;
    btnR_raw   = 1'b0;
    switch_raw = '0;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    for (int i = 2; i < 8; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
    for (int i = 9; i < 12; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};

    #2;
    chk("reset_buttonL", buttonL, 0);
    chk("reset_heldL",   heldL,   0);
    chk("reset_switch",  switch,  0);

    // Test 1: reset and clean press, table-driven.
    for (int i = 0; i < 12; i++) begin
      rst_n      = tbl[i].rst_n;
      btnL_raw   = tbl[i].bl;
      btnR_raw   = tbl[i].br;
      switch_raw = tbl[i].sw;
      step();
      chk($sformatf("tbl%0d_buttonL", i), buttonL, tbl[i].e_pl);
      chk($sformatf("tbl%0d_buttonR", i), buttonR, tbl[i].e_pr);
      chk($sformatf("tbl%0d_heldL", i),   heldL,   tbl[i].e_hl);
      chk($sformatf("tbl%0d_heldR", i),   heldR,   tbl[i].e_hr);
      chk($sformatf("tbl%0d_switch", i),  switch,  tbl[i].e_sw);
      $display("vec %0d: rst_n=%0b btnL=%0b btnR=%0b -> buttonL=%0b heldL=%0b buttonR=%0b",
               i, rst_n, btnL_raw, btnR_raw, buttonL, heldL, buttonR);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin step(); pulses += int'(buttonL); end
    chk("t1_no_extra_pulse", pulses, 0);
    chk("t1_still_held", heldL, 1);
    btnL_raw = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("t1_released", heldL, 0);
    $display("seq t1: press/hold/release done");

    // Test 2: bounce on the right button.
    pulses = 0;
    for (int t = 0; t < 4; t++) begin
      btnR_raw = (t % 2 == 0);
      for (int i = 0; i < 2; i++) begin
        step();
        pulses += int'(buttonR) + int'(heldR);
      end
    end
    btnR_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); pulses += int'(buttonR) + int'(heldR); end
    chk("t2_bounce_rejected", pulses, 0);
    $display("seq t2: bounce rejection done");

    // Test 3: long hold with release bounce.
    pulses = 0;
    lows   = 0;
    btnL_raw = 1'b1;
    for (int i = 0; i < 30; i++) begin step(); pulses += int'(buttonL); end
    btnL_raw = 1'b0;
    for (int i = 0; i < 2; i++) begin step(); pulses += int'(buttonL); lows += int'(!heldL); end
    btnL_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); pulses += int'(buttonL); lows += int'(!heldL); end
    btnL_raw = 1'b0;
    idx = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      pulses += int'(buttonL);
      if (idx < 0 && !heldL) idx = i;
    end
    chk("t3_one_pulse", pulses, 1);
    chk("t3_held_through_bounce", lows, 0);
    chk("t3_held_fall_edge", idx, 6);
    $display("seq t3: hold and release bounce done");

    // Test 4: simultaneous presses.
    btnL_raw = 1'b1;
    btnR_raw = 1'b1;
    idx_l = -1;
    idx_r = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (idx_l < 0 && buttonL) idx_l = i;
      if (idx_r < 0 && buttonR) idx_r = i;
    end
    chk("t4_left_pulse_edge",  idx_l, 6);
    chk("t4_right_pulse_edge", idx_r, 6);
    btnL_raw = 1'b0;
    btnR_raw = 1'b0;
    for (int i = 0; i < 10; i++) step();
    $display("seq t4: simultaneous presses done");

    // Test 5: switch word coherence.
    saw_a5 = 0;
    switch_raw = 16'h00A5;
    for (int i = 0; i < 2; i++) begin step(); saw_a5 += int'(switch == 16'h00A5); end
    switch_raw = 16'h12A5;
    idx_sw = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      saw_a5 += int'(switch == 16'h00A5);
      if (idx_sw < 0 && switch == 16'h12A5) idx_sw = i;
    end
    chk("t5_no_partial_word", saw_a5, 0);
    chk("t5_switch_update_edge", idx_sw, 6);
    $display("seq t5: switch coherence done, switch=0x%04h", switch);

    // Test 6: reset in the middle of a press window.
    pulses = 0;
    btnL_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); pulses += int'(buttonL); end
    rst_n = 1'b0;
    #1;
    chk("t6_async_clear_switch", switch, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      pulses += int'(buttonL);
      chk("t6_rst_heldL",   heldL,   0);
      chk("t6_rst_buttonR", buttonR, 0);
      chk("t6_rst_switch",  switch,  0);
    end
    chk("t6_no_pulse_before_release", pulses, 0);
    rst_n = 1'b1;
    pulses = 0;
    idx = -1;
    for (int i = 1; i <= 14; i++) begin
      step();
      pulses += int'(buttonL);
      if (idx < 0 && buttonL) idx = i;
    end
    chk("t6_pulse_edge_after_release", idx, 7);
    chk("t6_one_pulse", pulses, 1);
    btnL_raw = 1'b0;
    for (int i = 0; i < 10; i++) step();
    $display("seq t6: reset mid-debounce done");

    // Randomised traffic against the reference model.
    for (int seg = 0; seg < 15; seg++) begin
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(4, 0) == 0) btnL_raw = ~btnL_raw;
        if ($urandom_range(4, 0) == 0) btnR_raw = ~btnR_raw;
        if ($urandom_range(9, 0) == 0) begin
          case ($urandom_range(3, 0))
            0:       switch_raw = 16'h0000;
            1:       switch_raw = 16'hFFFF;
            2:       switch_raw = 16'h12A5;
            default: switch_raw = 16'($urandom);
          endcase
        end
        if (!rst_n) rst_n = 1'b1;
        else if ($urandom_range(299, 0) == 0) rst_n = 1'b0;
        step();
      end
      $display("random segment %0d: btnL=%0b btnR=%0b switch=0x%04h checks=%0d",
               seg, btnL_raw, btnR_raw, switch, n_total);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_io_input_conditioner
